pe_feed_ctrl: RTL and testbench
===============================

// Module: pe_feed_ctrl
// PURPOSE
//  Synthesizable load sequencer that replaces bench-side feeding of a PE array column.
//  Streams weight and fmap words from valid/ready sources into one pe instance.
//  Back-pressure comes from the PE fifo_full flags. Fmap goes in segments; before each
//  segment after the first, the block waits for shift_finish_flg.
//  Sits between the global buffer bus and pe. Config fields are sampled on start.
// PARAMETERS
//  DATA_WIDTH     16    fmap/weight/psum word width
//  CNT_WIDTH      8     width of per-segment and weight length counters
//  SEG_WIDTH      4     width of fmap segment-count field
//  TIMEOUT_CYC    1024  max cycles in WAIT_SHIFT before err asserts
// PORTS
//  clk               in   1           clock
//  rst               in   1           synchronous active-high reset
//  start             in   1           pulse: latch config, begin a load
//  weight_len        in   CNT_WIDTH   weight words to send (0 = none)
//  fmap_seg_len      in   CNT_WIDTH   fmap words per segment
//  fmap_seg_num      in   SEG_WIDTH   number of fmap segments (0 = none)
//  w_src_data/valid  in   DW/1        weight source
//  w_src_ready       out  1           weight accepted this cycle when valid&ready
//  f_src_data/valid  in   DW/1        fmap source
//  f_src_ready       out  1           fmap accepted this cycle when valid&ready
//  fifo_full_filter  in   1           from pe
//  fifo_full_fmap    in   1           from pe
//  shift_finish_flg  in   1           from pe
//  start_weight_load  out 1           1-cycle pulse to pe
//  start_feature_load out 1           1-cycle pulse to pe, once per segment
//  load_full_cloumn  out  1           high from first fmap START until DONE
//  weight_in/_en     out  DW/1        to pe
//  feature_in/_en    out  DW/1        to pe
//  busy              out  1           high from start until done
//  done              out  1           1-cycle pulse when both channels finish
//  err               out  1           sticky shift timeout; cleared by rst or start
// BEHAVIOUR
//  - Reset: all outputs 0; both channel FSMs return to IDLE; counters cleared.
//    Takes effect on any cycle, including mid-stream. No partial word is emitted.
//  - Weight FSM: IDLE -start-> START (pulse start_weight_load) -> STREAM -> DONE.
//  - Fmap FSM: IDLE -start-> START (pulse start_feature_load) -> STREAM -> WAIT_SHIFT
//    -shift_finish_flg-> START ... After the last segment it goes to DONE. It does
//    not wait for shift_finish_flg after the last segment.
//  - STREAM: x_src_ready = !fifo_full_x. x_in = x_src_data, combinational, 0 latency.
//    x_in_en = x_src_valid & x_src_ready. Word counter increments on each x_in_en.
//    The FSM leaves STREAM on the cycle the count reaches its length.
//  - Outside STREAM: src_ready = 0 and x_in_en = 0. x_in holds its last value.
//  - Zero length: weight_len = 0 or fmap_seg_num = 0 sends that channel straight to
//    DONE with no start pulse. fmap_seg_len = 0 with seg_num > 0 is treated as
//    seg_num = 0.
//  - done fires on the cycle the second channel reaches DONE (same cycle if both).
//    Both FSMs then go to IDLE and busy drops.
//  - start while busy is ignored.
//  - If shift_finish_flg rises in the same cycle the last word of a segment is sent,
//    that pulse is ignored. Only pulses seen in WAIT_SHIFT count.
//  - WAIT_SHIFT timeout: after TIMEOUT_CYC cycles, err = 1 and the FSM keeps waiting.
// CONFIGURATION
//  PE_FEED_PSUM_EN defined: adds a third channel.
//    Ports: psum_len, p_src_data/valid/ready, start_psum_in_load, psum_in, psum_in_en.
//    Same FSM as the weight channel. There is no PE back-pressure, so p_src_ready = 1
//    in STREAM. done waits for all three channels.
//  PE_FEED_PSUM_EN undefined: the ports are absent and done waits for two channels.
// STRUCTURE
//  Package pe_feed_pkg: chan_state_t enum (IDLE, START, STREAM, WAIT_SHIFT, DONE),
//  localparam widths, timeout counter width as $clog2(TIMEOUT_CYC+1).
//  Sub-module pe_feed_chan: one channel FSM plus word counter, with parameter SEGMENTED.
//  Instantiated for weight, fmap and psum; the top holds the done/busy/err logic.
// TESTING
//  1. rst mid-op; start weight_len=9, seg_len=6, seg_num=1, sources always valid,
//     no full -> 1 start pulse each; weight_in 1..9 and feature_in 1..6 on back-to-back
//     cycles; done 1 cycle after the later of the two last words.
//  2. fifo_full_fmap toggling every other cycle, seg_len=6 -> feature_in_en only in
//     cycles with full=0; exactly 6 words; no word lost or repeated.
//  3. seg_num=3, seg_len=12; shift_finish_flg pulsed 20 cycles after each segment ->
//     3 start_feature_load pulses, each 1 cycle after a flag; 36 words total;
//     load_full_cloumn steady high.
//  4. weight_len=0, seg_num=2 -> no start_weight_load; done after the 2nd segment;
//     start pulsed while busy -> no effect.
//  5. No shift_finish_flg, TIMEOUT_CYC=16 -> err rises 16 cycles into WAIT_SHIFT.
//     A later flag resumes the stream; err is cleared by the next start.
//  6. rst asserted mid-STREAM, then a new start -> all outputs 0 the cycle after rst;
//     the fresh load counts from 0.

Source files
------------

// File: rtl/pe_feed_pkg.sv
//------------------------------------------------------------------------------
// Module  : pe_feed_pkg
// Brief   : Shared types and constants for the PE feed sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pe_feed_pkg;

  localparam int DATA_WIDTH_DEF  = 16;
  localparam int CNT_WIDTH_DEF   = 8;
  localparam int SEG_WIDTH_DEF   = 4;
  localparam int TIMEOUT_CYC_DEF = 1024;

  // Per-channel load sequencer state
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    STREAM     = 3'd2,
    WAIT_SHIFT = 3'd3,
    DONE       = 3'd4
  } chan_state_t;

  // Width of a counter that must be able to hold the value cyc
  function automatic int tmo_width(input int cyc);
    return (cyc < 1) ? 1 : $clog2(cyc + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe_feed_chan.sv
//------------------------------------------------------------------------------
// Module  : pe_feed_chan
// Brief   : One load channel: start pulse, counted valid/ready stream into the
//           PE, optional multi-segment mode with shift-finish handshake and
//           sticky timeout while waiting for the shift.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pe_feed_chan
  import pe_feed_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int SEG_WIDTH   = SEG_WIDTH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter bit SEGMENTED   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_clr,
  input  logic [CNT_WIDTH-1:0]  i_len,
  input  logic [SEG_WIDTH-1:0]  i_seg_num,
  input  logic [DATA_WIDTH-1:0] i_src_data,
  input  logic                  i_src_valid,
  input  logic                  i_full,
  input  logic                  i_shift_finish,
  output logic                  o_src_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_en,
  output logic                  o_start_pulse,
  output chan_state_t           o_state,
  output logic                  o_err
);

  localparam int                c_TMO_W   = tmo_width(TIMEOUT_CYC);
  localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(TIMEOUT_CYC - 1);

  chan_state_t           r_state;
  logic [CNT_WIDTH-1:0]  r_len;
  logic [SEG_WIDTH-1:0]  r_seg_num;
  logic [CNT_WIDTH-1:0]  r_word_cnt;
  logic [SEG_WIDTH-1:0]  r_seg_cnt;
  logic [c_TMO_W-1:0]    r_tmo_cnt;
  logic                  r_err;
  logic                  r_start_pulse;
  logic [DATA_WIDTH-1:0] r_hold;

  logic [SEG_WIDTH-1:0]  w_seg_num_eff;
  logic                  w_zero;
  logic                  w_stream;
  logic [CNT_WIDTH-1:0]  w_cnt_next;
  logic [SEG_WIDTH-1:0]  w_seg_next;
  logic                  w_last_word;
  logic                  w_last_seg;

  // A non-segmented channel behaves as a single segment of i_len words
  assign w_seg_num_eff = SEGMENTED ? i_seg_num : SEG_WIDTH'(1);
  assign w_zero        = (i_len == '0) || (w_seg_num_eff == '0);

  assign w_stream    = (r_state == STREAM);
  assign o_src_ready = w_stream & ~i_full;
  assign o_data_en   = o_src_ready & i_src_valid;
  // Zero-latency pass-through while streaming, otherwise hold the last value
  assign o_data      = w_stream ? i_src_data : r_hold;

  assign w_cnt_next  = r_word_cnt + CNT_WIDTH'(1);
  assign w_seg_next  = r_seg_cnt + SEG_WIDTH'(1);
  assign w_last_word = (w_cnt_next == r_len);
  assign w_last_seg  = (w_seg_next == r_seg_num);

  assign o_start_pulse = r_start_pulse;
  assign o_state       = r_state;
  assign o_err         = r_err;

  // Channel FSM with word/segment counters, timeout and registered start pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_len         <= '0;
      r_seg_num     <= '0;
      r_word_cnt    <= '0;
      r_seg_cnt     <= '0;
      r_tmo_cnt     <= '0;
      r_err         <= 1'b0;
      r_start_pulse <= 1'b0;
      r_hold        <= '0;
    end else begin
      r_start_pulse <= 1'b0;
      if (w_stream) begin
        r_hold <= i_src_data;
      end
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_len      <= i_len;
            r_seg_num  <= w_seg_num_eff;
            r_word_cnt <= '0;
            r_seg_cnt  <= '0;
            r_tmo_cnt  <= '0;
            r_err      <= 1'b0;
            if (w_zero) begin
              r_state <= DONE;
            end else begin
              r_state       <= START;
              r_start_pulse <= 1'b1;
            end
          end
        end
        START: begin
          r_state <= STREAM;
        end
        STREAM: begin
          if (o_data_en) begin
            if (w_last_word) begin
              r_word_cnt <= '0;
              if (w_last_seg) begin
                r_state <= DONE;
              end else begin
                r_seg_cnt <= w_seg_next;
                r_tmo_cnt <= '0;
                r_state   <= WAIT_SHIFT;
              end
            end else begin
              r_word_cnt <= w_cnt_next;
            end
          end
        end
        WAIT_SHIFT: begin
          // Only a flag seen here releases the next segment; a timeout flags
          // the error but the channel keeps waiting.
          if (i_shift_finish) begin
            r_state       <= START;
            r_start_pulse <= 1'b1;
          end else if (!r_err) begin
            if (r_tmo_cnt == c_TMO_MAX) begin
              r_err <= 1'b1;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
            end
          end
        end
        DONE: begin
          if (i_clr) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/pe_feed_ctrl.sv
//------------------------------------------------------------------------------
// Module  : pe_feed_ctrl
// Brief   : Load sequencer feeding one PE: weight channel plus segmented fmap
//           channel, with done/busy/err aggregation.
//           Optional macro PE_FEED_PSUM_EN adds a psum input channel.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pe_feed_ctrl
  import pe_feed_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int SEG_WIDTH   = SEG_WIDTH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [CNT_WIDTH-1:0]  i_weight_len,
  input  logic [CNT_WIDTH-1:0]  i_fmap_seg_len,
  input  logic [SEG_WIDTH-1:0]  i_fmap_seg_num,
  input  logic [DATA_WIDTH-1:0] i_w_src_data,
  input  logic                  i_w_src_valid,
  output logic                  o_w_src_ready,
  input  logic [DATA_WIDTH-1:0] i_f_src_data,
  input  logic                  i_f_src_valid,
  output logic                  o_f_src_ready,
  input  logic                  i_fifo_full_filter,
  input  logic                  i_fifo_full_fmap,
  input  logic                  i_shift_finish_flg,
  output logic                  o_start_weight_load,
  output logic                  o_start_feature_load,
  output logic                  o_load_full_cloumn,
  output logic [DATA_WIDTH-1:0] o_weight_in,
  output logic                  o_weight_in_en,
  output logic [DATA_WIDTH-1:0] o_feature_in,
  output logic                  o_feature_in_en,
`ifdef PE_FEED_PSUM_EN
  input  logic [CNT_WIDTH-1:0]  i_psum_len,
  input  logic [DATA_WIDTH-1:0] i_p_src_data,
  input  logic                  i_p_src_valid,
  output logic                  o_p_src_ready,
  output logic                  o_start_psum_in_load,
  output logic [DATA_WIDTH-1:0] o_psum_in,
  output logic                  o_psum_in_en,
`endif
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  logic        r_busy;
  logic        w_start_acc;
  logic        w_all_done;
  chan_state_t w_state_w;
  chan_state_t w_state_f;
  logic        w_err_w;
  logic        w_err_f;
  logic        w_done_p;
  logic        w_err_p;

  // A start while a load is in progress is ignored
  assign w_start_acc = i_start & ~r_busy;

  pe_feed_chan #(
    .DATA_WIDTH  (DATA_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH),
    .SEG_WIDTH   (SEG_WIDTH),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SEGMENTED   (1'b0)
  ) u_weight (
    .clk            (clk),
    .rst            (rst),
    .i_start        (w_start_acc),
    .i_clr          (w_all_done),
    .i_len          (i_weight_len),
    .i_seg_num      ('0),
    .i_src_data     (i_w_src_data),
    .i_src_valid    (i_w_src_valid),
    .i_full         (i_fifo_full_filter),
    .i_shift_finish (1'b0),
    .o_src_ready    (o_w_src_ready),
    .o_data         (o_weight_in),
    .o_data_en      (o_weight_in_en),
    .o_start_pulse  (o_start_weight_load),
    .o_state        (w_state_w),
    .o_err          (w_err_w)
  );

  pe_feed_chan #(
    .DATA_WIDTH  (DATA_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH),
    .SEG_WIDTH   (SEG_WIDTH),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SEGMENTED   (1'b1)
  ) u_fmap (
    .clk            (clk),
    .rst            (rst),
    .i_start        (w_start_acc),
    .i_clr          (w_all_done),
    .i_len          (i_fmap_seg_len),
    .i_seg_num      (i_fmap_seg_num),
    .i_src_data     (i_f_src_data),
    .i_src_valid    (i_f_src_valid),
    .i_full         (i_fifo_full_fmap),
    .i_shift_finish (i_shift_finish_flg),
    .o_src_ready    (o_f_src_ready),
    .o_data         (o_feature_in),
    .o_data_en      (o_feature_in_en),
    .o_start_pulse  (o_start_feature_load),
    .o_state        (w_state_f),
    .o_err          (w_err_f)
  );

`ifdef PE_FEED_PSUM_EN
  chan_state_t w_state_p;

  // Psum has no PE back-pressure, so it is ready whenever streaming
  pe_feed_chan #(
    .DATA_WIDTH  (DATA_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH),
    .SEG_WIDTH   (SEG_WIDTH),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SEGMENTED   (1'b0)
  ) u_psum (
    .clk            (clk),
    .rst            (rst),
    .i_start        (w_start_acc),
    .i_clr          (w_all_done),
    .i_len          (i_psum_len),
    .i_seg_num      ('0),
    .i_src_data     (i_p_src_data),
    .i_src_valid    (i_p_src_valid),
    .i_full         (1'b0),
    .i_shift_finish (1'b0),
    .o_src_ready    (o_p_src_ready),
    .o_data         (o_psum_in),
    .o_data_en      (o_psum_in_en),
    .o_start_pulse  (o_start_psum_in_load),
    .o_state        (w_state_p),
    .o_err          (w_err_p)
  );

  assign w_done_p = (w_state_p == DONE);
`else
  assign w_done_p = 1'b1;
  assign w_err_p  = 1'b0;
`endif

  // done is decoded from channel state registers: one cycle, all channels DONE
  assign w_all_done = r_busy & (w_state_w == DONE) & (w_state_f == DONE) & w_done_p;

  assign o_done             = w_all_done;
  assign o_busy             = r_busy;
  assign o_err              = w_err_w | w_err_f | w_err_p;
  assign o_load_full_cloumn = (w_state_f == START) | (w_state_f == STREAM) |
                              (w_state_f == WAIT_SHIFT);

  // busy spans from an accepted start to the done cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
    end else if (w_start_acc) begin
      r_busy <= 1'b1;
    end else if (w_all_done) begin
      r_busy <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pe_feed_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_pe_feed_ctrl
// Brief   : Directed scoreboard bench for pe_feed_ctrl (default build).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pe_feed_ctrl;

  localparam int DW  = 16;
  localparam int CW  = 8;
  localparam int SW  = 4;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [CW-1:0] wl = '0;
  logic [CW-1:0] sl = '0;
  logic [SW-1:0] sn = '0;
  logic [DW-1:0] w_data = 16'd1;
  logic [DW-1:0] f_data = 16'd1;
  logic          w_valid = 1'b1;
  logic          f_valid = 1'b1;
  logic          full_w = 1'b0;
  logic          full_f = 1'b0;
  logic          shf = 1'b0;

  logic          w_ready, f_ready, sw_p, sf_p, lfc, w_en, f_en, busy, done, err;
  logic [DW-1:0] w_out, f_out;

  always #5 clk = ~clk;

  pe_feed_ctrl #(
    .DATA_WIDTH  (DW),
    .CNT_WIDTH   (CW),
    .SEG_WIDTH   (SW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_start              (i_start),
    .i_weight_len         (wl),
    .i_fmap_seg_len       (sl),
    .i_fmap_seg_num       (sn),
    .i_w_src_data         (w_data),
    .i_w_src_valid        (w_valid),
    .o_w_src_ready        (w_ready),
    .i_f_src_data         (f_data),
    .i_f_src_valid        (f_valid),
    .o_f_src_ready        (f_ready),
    .i_fifo_full_filter   (full_w),
    .i_fifo_full_fmap     (full_f),
    .i_shift_finish_flg   (shf),
    .o_start_weight_load  (sw_p),
    .o_start_feature_load (sf_p),
    .o_load_full_cloumn   (lfc),
    .o_weight_in          (w_out),
    .o_weight_in_en       (w_en),
    .o_feature_in         (f_out),
    .o_feature_in_en      (f_en),
    .o_busy               (busy),
    .o_done               (done),
    .o_err                (err)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int ww_cnt = 0, fw_cnt = 0, sw_cnt = 0, sf_cnt = 0, done_cnt = 0;
  int first_w = 0, last_w = 0, first_f = 0, last_f = 0, done_cyc = 0;
  bit acc_w = 1'b0, acc_f = 1'b0, tog_en = 1'b0, chk_lfc = 1'b0;
  logic [DW-1:0] wq[$];
  logic [DW-1:0] fq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every accepted word, counts pulses
  always @(negedge clk) begin
    logic [DW-1:0] e;
    cyc++;
    acc_w = (w_en === 1'b1);
    acc_f = (f_en === 1'b1);
    if (acc_w) begin
      check("w_word_expected", 32'(wq.size() > 0), 32'd1);
      if (wq.size() > 0) begin
        e = wq.pop_front();
        check("w_word", 32'(w_out), 32'(e));
      end
      if (ww_cnt == 0) first_w = cyc;
      last_w = cyc;
      ww_cnt++;
    end
    if (acc_f) begin
      check("f_word_expected", 32'(fq.size() > 0), 32'd1);
      if (fq.size() > 0) begin
        e = fq.pop_front();
        check("f_word", 32'(f_out), 32'(e));
      end
      if (fw_cnt == 0) first_f = cyc;
      last_f = cyc;
      fw_cnt++;
    end
    if (tog_en) check("f_en_while_full", 32'(f_en & full_f), 32'd0);
    if (chk_lfc) check("load_full_cloumn_high", 32'(lfc), 32'd1);
    if (sw_p === 1'b1) sw_cnt++;
    if (sf_p === 1'b1) sf_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Source model: advance to the next word after one was accepted
  always @(posedge clk) begin
    #1;
    if (acc_w) w_data = w_data + 16'd1;
    if (acc_f) f_data = f_data + 16'd1;
    if (tog_en) full_f = ~full_f;
  end

  task automatic do_start(input int w, input int s, input int n);
    @(negedge clk);
    wq.delete();
    fq.delete();
    w_data = 16'd1;
    f_data = 16'd1;
    for (int i = 0; i < w; i++) wq.push_back(DW'(i + 1));
    for (int i = 0; i < s * n; i++) fq.push_back(DW'(i + 1));
    wl = CW'(w);
    sl = CW'(s);
    sn = SW'(n);
    ww_cnt = 0; fw_cnt = 0; sw_cnt = 0; sf_cnt = 0; done_cnt = 0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_fw(input string tag, input int n, input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      #1;
      if (fw_cnt >= n) seen = 1'b1;
    end
    check({tag, "_fmap_words_reached"}, 32'(seen), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_lfc"}, 32'(lfc), 32'd0);
    check({tag, "_w_en"}, 32'(w_en), 32'd0);
    check({tag, "_f_en"}, 32'(f_en), 32'd0);
    check({tag, "_sw"}, 32'(sw_p), 32'd0);
    check({tag, "_sf"}, 32'(sf_p), 32'd0);
    check({tag, "_w_in"}, 32'(w_out), 32'd0);
    check({tag, "_f_in"}, 32'(f_out), 32'd0);
    check({tag, "_w_rdy"}, 32'(w_ready), 32'd0);
    check({tag, "_f_rdy"}, 32'(f_ready), 32'd0);
  endtask

  initial begin
    int exp_done;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // T1: reset mid-operation, then a plain single-segment load
    do_start(9, 6, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_zero("t1_rst");
    rst = 1'b0;
    do_start(9, 6, 1);
    wait_done("t1", 60);
    check("t1_sw_pulses", 32'(sw_cnt), 32'd1);
    check("t1_sf_pulses", 32'(sf_cnt), 32'd1);
    check("t1_w_words", 32'(ww_cnt), 32'd9);
    check("t1_f_words", 32'(fw_cnt), 32'd6);
    check("t1_w_b2b", 32'(last_w - first_w), 32'd8);
    check("t1_f_b2b", 32'(last_f - first_f), 32'd5);
    check("t1_same_first", 32'(first_w - first_f), 32'd0);
    exp_done = ((last_w > last_f) ? last_w : last_f) + 1;
    check("t1_done_cycle", 32'(done_cyc), 32'(exp_done));
    @(negedge clk);
    #1;
    check("t1_busy_dropped", 32'(busy), 32'd0);

    // T2: fmap fifo full toggling every cycle
    @(negedge clk);
    full_f = 1'b0;
    tog_en = 1'b1;
    do_start(3, 6, 1);
    wait_done("t2", 80);
    tog_en = 1'b0;
    full_f = 1'b0;
    check("t2_f_words", 32'(fw_cnt), 32'd6);
    check("t2_f_span", 32'(last_f - first_f), 32'd10);
    check("t2_w_words", 32'(ww_cnt), 32'd3);
    check("t2_fq_empty", 32'(fq.size()), 32'd0);

    // T3: three segments released by shift_finish 20 cycles after each
    do_start(5, 12, 3);
    chk_lfc = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_fw("t3", 12 * (k + 1), 200);
      if (k < 2) begin
        repeat (20) @(negedge clk);
        shf = 1'b1;
        @(negedge clk);
        shf = 1'b0;
        #1;
        check("t3_start_after_flag", 32'(sf_p), 32'd1);
      end
    end
    chk_lfc = 1'b0;
    wait_done("t3", 60);
    check("t3_sf_pulses", 32'(sf_cnt), 32'd3);
    check("t3_f_words", 32'(fw_cnt), 32'd36);
    check("t3_w_words", 32'(ww_cnt), 32'd5);

    // T4: no weights, two segments, start while busy ignored
    do_start(0, 5, 2);
    wait_fw("t4", 5, 100);
    repeat (3) @(negedge clk);
    i_start = 1'b1;
    wl = 8'd7;
    @(negedge clk);
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    shf = 1'b1;
    @(negedge clk);
    shf = 1'b0;
    wait_done("t4", 100);
    check("t4_no_sw", 32'(sw_cnt), 32'd0);
    check("t4_sf_pulses", 32'(sf_cnt), 32'd2);
    check("t4_f_words", 32'(fw_cnt), 32'd10);
    check("t4_done_cycle", 32'(done_cyc), 32'(last_f + 1));
    repeat (5) @(negedge clk);
    #1;
    check("t4_no_late_w", 32'(ww_cnt + sw_cnt), 32'd0);
    check("t4_idle", 32'(busy), 32'd0);

    // T5: shift timeout raises sticky err, later flag resumes
    do_start(0, 4, 2);
    wait_fw("t5", 4, 100);
    repeat (16) @(negedge clk);
    #1;
    check("t5_err_before_timeout", 32'(err), 32'd0);
    @(negedge clk);
    #1;
    check("t5_err_at_timeout", 32'(err), 32'd1);
    repeat (5) @(negedge clk);
    shf = 1'b1;
    @(negedge clk);
    shf = 1'b0;
    wait_done("t5", 100);
    check("t5_f_words", 32'(fw_cnt), 32'd8);
    check("t5_err_sticky", 32'(err), 32'd1);
    do_start(2, 2, 1);
    #1;
    check("t5_err_cleared_by_start", 32'(err), 32'd0);
    wait_done("t5b", 40);

    // T6: reset mid-stream, then a fresh load from zero
    do_start(20, 20, 1);
    wait_fw("t6", 5, 100);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_zero("t6_rst");
    rst = 1'b0;
    do_start(4, 3, 1);
    wait_done("t6", 60);
    check("t6_w_words", 32'(ww_cnt), 32'd4);
    check("t6_f_words", 32'(fw_cnt), 32'd3);
    check("t6_wq_empty", 32'(wq.size()), 32'd0);
    check("t6_fq_empty", 32'(fq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
